// File: rtl/spi_report_rx_if.sv
`default_nettype none
//==============================================================================
// Module   : spi_report_rx_if
// Purpose  : Bundles the SPI pins and the CPU register-read port of
//            spi_report_rx. The master modport is the host/CPU side, the slave
//            modport is the receiver.
// Revision : 1.0 - initial release
//==============================================================================
interface spi_report_rx_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 4
);
  localparam int SEL_W = $clog2(NREGS);

  // SPI pins, asynchronous to clk
  logic              ss;
  logic              sclk;
  logic              mosi;
  // CPU read port
  logic [SEL_W-1:0]  rreg;
  logic [DATA_W-1:0] rdata;
  logic              rnew;
  logic              rack;
  logic              irq;
  logic [7:0]        err_cnt;

  modport master (
    output ss, sclk, mosi, rreg, rack,
    input  rdata, rnew, irq, err_cnt
  );

  modport slave (
    input  ss, sclk, mosi, rreg, rack,
    output rdata, rnew, irq, err_cnt
  );
endinterface

`default_nettype wire

// File: rtl/spi_report_rx.sv
`default_nettype none
//==============================================================================
// Module   : spi_report_rx
// Purpose  : Oversampled SPI (mode 0, MSB first) slave receiving SS-framed
//            reports {payload, index}. The payload lands in report register
//            [index]; per-register new flags, an IRQ and a saturating error
//            counter are provided.
// Options  : define SPI_REPORT_RX_CRC_EN to append a CRC-8 byte (poly 0x07,
//            init 0x00) to every frame and reject frames whose CRC mismatches.
// Revision : 1.0 - initial release
//==============================================================================
module spi_report_rx #(
  parameter int DATA_W      = 32,
  parameter int ID_W        = 8,
  parameter int NREGS       = 4,
  parameter int SYNC_STAGES = 2
) (
  input wire             clk,
  input wire             resetn,
  spi_report_rx_if.slave bus
);

`ifdef SPI_REPORT_RX_CRC_EN
  localparam int CRC_W   = 8;
`else
  localparam int CRC_W   = 0;
`endif
  localparam int BODY_W  = DATA_W + ID_W;
  localparam int FRAME_W = BODY_W + CRC_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int SEL_W   = $clog2(NREGS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_WAIT_SS = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] fill_q,      fill_d;
  logic                   sclk_prev_q, sclk_prev_d;

  logic ss_s;
  logic sclk_s;
  logic mosi_s;
  logic sync_ready;
  logic sclk_rise;

  // Shift the raw pins into the synchroniser chains; fill tracks when the
  // chains hold real pin samples rather than their reset values.
  always_comb begin
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0],   bus.ss};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
    fill_d      = {fill_q[SYNC_STAGES-2:0],      1'b1};
    sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
  end

  assign ss_s       = ss_sync_q[SYNC_STAGES-1];
  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign sync_ready = fill_q[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_prev_q;

  // Synchroniser flops; idle bus levels after reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ss_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      fill_q      <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      ss_sync_q   <= ss_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      fill_q      <= fill_d;
      sclk_prev_q <= sclk_prev_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame decode
  // ---------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic                 overrun_q, overrun_d;
  logic                 armed_q,   armed_d;

  logic [DATA_W-1:0]    payload;
  logic [ID_W-1:0]      idx;
  logic                 idx_ok;
  logic                 crc_ok;
  logic                 frame_ok;
  logic                 wr_en;
  logic                 err_inc;
  logic [SEL_W-1:0]     wr_idx;

  assign payload  = shift_q[FRAME_W-1 -: DATA_W];
  assign idx      = shift_q[CRC_W +: ID_W];
  assign idx_ok   = 32'(idx) < 32'(NREGS);
  assign wr_idx   = idx[SEL_W-1:0];
  assign frame_ok = idx_ok & crc_ok;

`ifdef SPI_REPORT_RX_CRC_EN
  logic [7:0] crc_q, crc_d;

  // Serial CRC-8 over payload+index; restarts whenever the FSM is idle
  always_comb begin
    crc_d = crc_q;
    if (state_q == ST_IDLE) begin
      crc_d = 8'h00;
    end else if (state_q == ST_SHIFT && !ss_s && sclk_rise &&
                 cnt_q < CNT_W'(BODY_W)) begin
      crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ mosi_s) ? 8'h07 : 8'h00);
    end
  end

  // CRC accumulator
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_ok = (crc_q == shift_q[7:0]);
`else
  assign crc_ok = 1'b1;
`endif

  // Next-state logic: frame assembly, commit decision and error events.
  // armed blocks reception after reset until ss has been seen high, so a
  // frame interrupted by reset is not picked up part-way through.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    overrun_d = overrun_q;
    armed_d   = armed_q;
    wr_en     = 1'b0;
    err_inc   = 1'b0;

    if (sync_ready && ss_s) begin
      armed_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (armed_q && !ss_s) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (ss_s) begin
          state_d = ST_IDLE;
          if (cnt_q != '0) begin
            err_inc = 1'b1;
          end
        end else if (sclk_rise) begin
          shift_d = {shift_q[FRAME_W-2:0], mosi_s};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(FRAME_W - 1)) begin
            state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        if (frame_ok) begin
          wr_en = 1'b1;
        end else begin
          err_inc = 1'b1;
        end
        overrun_d = 1'b0;
        state_d   = ST_WAIT_SS;
      end
      ST_WAIT_SS: begin
        if (ss_s) begin
          state_d = ST_IDLE;
        end else if (sclk_rise && !overrun_q) begin
          err_inc   = 1'b1;
          overrun_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Receive FSM and shift datapath
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      overrun_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      overrun_q <= overrun_d;
      armed_q   <= armed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Report registers, new flags, IRQ and error counter
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  new_q,  new_d;
  logic              irq_q,  irq_d;
  logic [7:0]        err_q,  err_d;
  logic              rsel_ok;

  assign rsel_ok = 32'(bus.rreg) < 32'(NREGS);

  // Register writes and flag updates; a commit overrides a same-cycle rack
  always_comb begin
    regs_d = regs_q;
    new_d  = new_q;
    if (bus.rack && rsel_ok) begin
      new_d[bus.rreg] = 1'b0;
    end
    if (wr_en) begin
      regs_d[wr_idx] = payload;
      new_d[wr_idx]  = 1'b1;
    end
    irq_d = |new_q;
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  // Report register file and status flops
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      new_q <= '0;
      irq_q <= 1'b0;
      err_q <= 8'h00;
    end else begin
      regs_q <= regs_d;
      new_q  <= new_d;
      irq_q  <= irq_d;
      err_q  <= err_d;
    end
  end

  assign bus.rdata   = rsel_ok ? regs_q[bus.rreg] : '0;
  assign bus.rnew    = rsel_ok ? new_q[bus.rreg]  : 1'b0;
  assign bus.irq     = irq_q;
  assign bus.err_cnt = err_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_report_rx.sv
`default_nettype none
//==============================================================================
// Module   : tb_spi_report_rx
// Purpose  : Directed, table-driven bench for spi_report_rx (default params).
//            Honours SPI_REPORT_RX_CRC_EN when defined for the build.
// Revision : 1.0 - initial release
//==============================================================================
module tb_spi_report_rx;
  localparam int NREGS = 4;
`ifdef SPI_REPORT_RX_CRC_EN
  localparam int FW = 48;
`else
  localparam int FW = 40;
`endif

  typedef struct {
    logic [39:0] body;   // {payload, index}
    int          mode;   // 0 full, 1 short(20), 2 overrun(FW+5), 3 empty
    int          wr;     // register written, -1 none
    logic [31:0] data;   // value expected in that register
    int          err;    // expected err_cnt afterwards
  } vec_t;

  logic        clk    = 1'b0;
  logic        resetn = 1'b0;
  int          tests  = 0;
  int          fails  = 0;
  logic [31:0] m_regs [NREGS];
  logic [NREGS-1:0] m_new;
  int          m_err;
  bit          lat_chk = 1'b0;
  bit          do_rack = 1'b0;
  logic [31:0] lat_old, lat_new;
  vec_t        vecs [10];

  always #5 clk = ~clk;

  spi_report_rx_if #(.DATA_W(32), .NREGS(NREGS)) bus ();

  spi_report_rx #(
    .DATA_W(32), .ID_W(8), .NREGS(NREGS), .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

`ifdef SPI_REPORT_RX_CRC_EN
  function automatic logic [7:0] crc8(input logic [39:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 39; i >= 0; i--) begin
      c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
    end
    return c;
  endfunction
`endif

  function automatic logic [47:0] build(input logic [39:0] body);
`ifdef SPI_REPORT_RX_CRC_EN
    return {body, crc8(body)};
`else
    return {8'h00, body};
`endif
  endfunction

  function automatic int npulse(input int mode);
    case (mode)
      0:       return FW;
      1:       return 20;
      2:       return FW + 5;
      default: return 0;
    endcase
  endfunction

  task automatic pulse_bits(input logic [47:0] full, input int first, input int cnt);
    for (int i = first; i < first + cnt; i++) begin
      bus.mosi = (i < FW) ? full[FW-1-i] : 1'b0;
      #20 bus.sclk = 1'b1;
      #20 bus.sclk = 1'b0;
    end
  endtask

  // One SS-framed transfer; last SCLK rise lands 7 after a clk posedge p,
  // so the commit edge is p+40.
  task automatic send_full(input logic [47:0] full, input int pulses, input int jitter);
    @(negedge clk);
    #2;
    if (jitter > 0) #(jitter);
    bus.ss = 1'b0;
    #40;
    pulse_bits(full, 0, pulses);
    #6;
    if (lat_chk) begin
      check("lat_before_data", 64'(bus.rdata), 64'(lat_old));
      check("lat_before_new", 64'(bus.rnew), 64'(1'b0));
    end
    #4;
    if (do_rack) bus.rack = 1'b1;
    #8;
    bus.rack = 1'b0;
    if (lat_chk) begin
      check("lat_after_data", 64'(bus.rdata), 64'(lat_new));
      check("lat_after_new", 64'(bus.rnew), 64'(1'b1));
      check("lat_irq_low", 64'(bus.irq), 64'(1'b0));
    end
    #10;
    if (lat_chk) check("lat_irq_high", 64'(bus.irq), 64'(1'b1));
    #2;
    bus.ss = 1'b1;
    #100;
  endtask

  task automatic check_all(input string tag);
    @(negedge clk);
    for (int r = 0; r < NREGS; r++) begin
      bus.rreg = 2'(r);
      #1;
      check($sformatf("%s_rdata%0d", tag, r), 64'(bus.rdata), 64'(m_regs[r]));
      check($sformatf("%s_rnew%0d", tag, r), 64'(bus.rnew), 64'(m_new[r]));
    end
    check({tag, "_irq"}, 64'(bus.irq), 64'(|m_new));
    check({tag, "_err"}, 64'(bus.err_cnt), 64'(m_err));
  endtask

  task automatic rack_pulse(input int r);
    bus.rreg = 2'(r);
    @(negedge clk);
    #2 bus.rack = 1'b1;
    #6 bus.rack = 1'b0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) m_regs[r] = 32'h0;
    m_new = '0;
    m_err = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    logic [47:0] full;
    logic [31:0] pd;
    int          idx;

    vecs[0] = '{40'hDEADBEEF_01, 0,  1, 32'hDEADBEEF, 0};
    vecs[1] = '{40'h12345678_00, 0,  0, 32'h12345678, 0};
    vecs[2] = '{40'hA5A5A5A5_03, 0,  3, 32'hA5A5A5A5, 0};
    vecs[3] = '{40'h55555555_02, 1, -1, 32'h0,        1};
    vecs[4] = '{40'hCAFEF00D_07, 0, -1, 32'h0,        2};
    vecs[5] = '{40'hFFFFFFFF_FF, 0, -1, 32'h0,        3};
    vecs[6] = '{40'h00000001_02, 0,  2, 32'h00000001, 3};
    vecs[7] = '{40'h11111111_01, 2,  1, 32'h11111111, 4};
    vecs[8] = '{40'h22222222_01, 0,  1, 32'h22222222, 4};
    vecs[9] = '{40'h33333333_00, 3, -1, 32'h0,        4};

    bus.ss = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
    bus.rreg = '0; bus.rack = 1'b0;
    model_reset();
    #23;
    check_all("reset");
    resetn = 1'b1;
    #100;

    // Table-driven frames; every new flag is acknowledged afterwards
    for (int v = 0; v < 10; v++) begin
      lat_chk = (vecs[v].mode == 0) && (vecs[v].wr >= 0);
      if (lat_chk) begin
        bus.rreg = 2'(vecs[v].wr);
        lat_old  = m_regs[vecs[v].wr];
        lat_new  = vecs[v].data;
      end
      send_full(build(vecs[v].body), npulse(vecs[v].mode), 0);
      lat_chk = 1'b0;
      if (vecs[v].wr >= 0) begin
        m_regs[vecs[v].wr] = vecs[v].data;
        m_new[vecs[v].wr]  = 1'b1;
      end
      m_err = vecs[v].err;
      check_all($sformatf("vec%0d", v));
      if (vecs[v].wr >= 0) begin
        rack_pulse(vecs[v].wr);
        m_new[vecs[v].wr] = 1'b0;
        #20;
      end
    end

    // rack clears the flag next edge, irq drops one edge later
    send_full(build(40'hDEADBEEF_01), FW, 0);
    m_regs[1] = 32'hDEADBEEF; m_new[1] = 1'b1;
    check_all("pre_rack");
    bus.rreg = 2'd1;
    @(negedge clk);
    #2 bus.rack = 1'b1;
    #6 bus.rack = 1'b0;
    check("rack_clear", 64'(bus.rnew), 64'(1'b0));
    check("rack_irq_hold", 64'(bus.irq), 64'(1'b1));
    #10;
    check("rack_irq_drop", 64'(bus.irq), 64'(1'b0));
    m_new[1] = 1'b0;

    // Commit and rack on the same register in the same cycle: write wins
    send_full(build(40'h0BADF00D_01), FW, 0);
    m_regs[1] = 32'h0BADF00D; m_new[1] = 1'b1;
    bus.rreg = 2'd1;
    do_rack  = 1'b1;
    send_full(build(40'h5EED5EED_01), FW, 0);
    do_rack  = 1'b0;
    m_regs[1] = 32'h5EED5EED;
    check_all("write_wins");

    // rack on a register whose flag is clear changes nothing
    rack_pulse(0);
    #20;
    check_all("rack_idle");

`ifdef SPI_REPORT_RX_CRC_EN
    // CRC of {0x00000000, 0x01} is 0x07; 0x06 must be rejected
    send_full(48'h00000000_01_06, FW, 0);
    m_err = m_err + 1;
    check_all("crc_bad");
    send_full(48'h00000000_01_07, FW, 0);
    m_regs[1] = 32'h0; m_new[1] = 1'b1;
    check_all("crc_good");
`endif

    // Clean frames at clk = 4x SCLK with random phase: no errors expected
    for (int k = 0; k < 100; k++) begin
      pd   = $urandom;
      idx  = $urandom_range(0, NREGS - 1);
      full = build({pd, 8'(idx)});
      send_full(full, FW, $urandom_range(0, 9));
      m_regs[idx] = pd;
      m_new[idx]  = 1'b1;
      bus.rreg = 2'(idx);
      #1;
      check($sformatf("rand%0d_data", k), 64'(bus.rdata), 64'(pd));
    end
    check_all("rand");

    // Reset in the middle of a frame, then a frame with no ss toggle
    full = build(40'h77777777_01);
    @(negedge clk);
    #2 bus.ss = 1'b0;
    #40;
    pulse_bits(full, 0, 17);
    resetn = 1'b0;
    model_reset();
    #30;
    check_all("midreset");
    @(negedge clk);
    #2 resetn = 1'b1;
    pulse_bits(full, 17, FW - 17);
    pulse_bits(build(40'h66666666_02), 0, FW);
    #40 bus.ss = 1'b1;
    #100;
    check_all("no_toggle");
    bus.rreg = 2'd2;
    lat_chk  = 1'b1;
    lat_old  = 32'h0;
    lat_new  = 32'h3C3C3C3C;
    send_full(build(40'h3C3C3C3C_02), FW, 0);
    lat_chk  = 1'b0;
    m_regs[2] = 32'h3C3C3C3C; m_new[2] = 1'b1;
    check_all("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
